img_alu_seq: RTL and testbench
==============================

Name: img_alu_seq

Overview:
- Frame-level sequencer for the combinational pixel ALU (invert / color map / contrast / threshold).
- On a start command it streams LEN pixels from a source frame-buffer region through the ALU and writes the results to a destination region, at 1 pixel/clk when not stalled.
- Sits between the CPU-side coprocessor register interface (start, func, bases, len) and the frame-buffer memory ports. The ALU is instantiated beside it and connected by the alu_* ports.

Parameters:
- ADDR_W, 17, frame-buffer word address width (320x240 = 76800 pixels fits).
- PIX_W, 12, pixel width (4:4:4 RGB).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: synchronous, active-low. Single clock domain.
- start  in  1  one-cycle command strobe; accepted only in IDLE
- func  in  2  ALU opcode, latched at start
- src_base  in  ADDR_W  first source address, latched at start
- dst_base  in  ADDR_W  first destination address, latched at start
- len  in  ADDR_W  pixel count, latched at start; 0 is legal
- rd_hold  in  1  read port lent to display this cycle; no new read may issue
- rd_en  out  1  read request
- rd_addr  out  ADDR_W  read address
- rd_data  in  PIX_W  read data, valid exactly 1 cycle after rd_en
- alu_func  out  2  latched func to ALU
- alu_pixel_in  out  PIX_W  = rd_data, passed through combinationally
- alu_pixel_out  in  PIX_W  ALU result
- wr_en  out  1  write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  PIX_W  write data
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- perf_cycles  out  ADDR_W+8  see Optional Feature

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; rd_en, wr_en, busy, done = 0; addresses, counters, alu_func and wr_data = 0. Reset mid-job abandons the job: no further rd_en/wr_en and no done pulse.
- FSM:
  - IDLE: on start, latch func/bases/len. Go to RUN if len!=0, else go to DONE.
  - RUN: while issued<len, assert rd_en whenever rd_hold=0. When the last read has issued, go to DRAIN.
  - DRAIN: wait until no pixel is in flight, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. start is ignored in DONE.
- Pipeline, with valid bits v1 (read issued last cycle) and v2 (result register full):
  - Stage0: rd_en=1, rd_addr=src_base+issued; issued increments.
  - Stage1: alu_pixel_in=rd_data; alu_pixel_out is captured into wr_data, and wr_addr=dst_base+index.
  - Stage2: wr_en=1.
- Latency: start at T, first rd_en at T+1, first wr_en at T+3. With no hold: last write at T+len+2, done at T+len+3.
- rd_hold gates new reads only. In-flight pixels still complete, because the write port is not shared. If rd_hold is high at the cycle an issue would occur, that read slips to the next cycle. Write order always equals read order.
- busy=1 in RUN and DRAIN. busy=0 in IDLE and DONE.
- start while busy or in DONE is ignored; the latched config is unchanged.
- Address arithmetic is modulo 2^ADDR_W: base+index wraps silently.
- len=0: done pulses at T+1; no rd_en or wr_en.
- alu_func holds its latched value until the next accepted start.

Optional Feature:
- Macro IMG_ALU_SEQ_PERF_EN.
- Defined: perf_cycles counts busy cycles of the current or last job. It clears on an accepted start, holds after done, and saturates at all-ones.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package img_coproc_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - func codes FUNC_INVERT=2'b00, FUNC_COLOR=2'b01, FUNC_CONTRAST=2'b10, FUNC_THRESH=2'b11;
  - PIX_W and the default ADDR_W.
- One natural sub-module: img_alu_seq_pipe, the v1/v2 valid pipeline with the address/result registers. The FSM and counters stay in the top level.

Test Plan:
- Invert: func=00, len=4, src_base=0x100 holding 0x123,0x000,0xFFF,0xA5A; dst_base=0x200. Expect writes to 0x200..0x203 of 0xEDC,0xFFF,0x000,0x5A5. First wr_en at T+3, done at T+7.
- Threshold: func=11, src pixel 0x7A6. Expect wr_data=0xFF0. Color map: func=01, pixel 0x050 -> 0x0F0, pixel 0x0E0 -> 0xF00.
- rd_hold high for 3 cycles mid-job (len=8). Expect no rd_en during hold, 8 writes in order, done delayed by exactly 3 cycles.
- len=0: done at T+1, zero rd_en/wr_en. A second start while busy (len=2 job running) is ignored: exactly 2 writes.
- Wrap: src_base=0x1FFFF, len=2. Expect rd_addr 0x1FFFF then 0x00000.
- rst_n=0 during RUN with len=16: outputs 0 the next cycle, no done. A fresh start afterwards completes normally. With IMG_ALU_SEQ_PERF_EN and len=4, no hold: perf_cycles=6.

Source files
------------

// File: rtl/img_coproc_pkg.sv
// Shared definitions for the image coprocessor: sequencer states, ALU opcodes
// and default widths.
package img_coproc_pkg;

  localparam int PIX_W      = 12;
  localparam int ADDR_W_DEF = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    FUNC_INVERT   = 2'b00,
    FUNC_COLOR    = 2'b01,
    FUNC_CONTRAST = 2'b10,
    FUNC_THRESH   = 2'b11
  } alu_func_e;

  function automatic int perfWidth(input int addrW);
    return addrW + 8;
  endfunction

endpackage

// File: rtl/img_alu_seq_if.sv
// Bundle of command, frame-buffer and ALU signals around img_alu_seq.
// The slave modport is the sequencer; the master modport is the CPU/memory side.
interface img_alu_seq_if #(
  parameter int ADDR_W = img_coproc_pkg::ADDR_W_DEF,
  parameter int PIX_W  = img_coproc_pkg::PIX_W
);

  logic              start;
  logic [1:0]        func;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] len;
  logic              rd_hold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [1:0]        alu_func;
  logic [PIX_W-1:0]  alu_pixel_in;
  logic [PIX_W-1:0]  alu_pixel_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W+7:0] perf_cycles;

  modport master (
    output start, func, src_base, dst_base, len, rd_hold, rd_data, alu_pixel_out,
    input  rd_en, rd_addr, alu_func, alu_pixel_in, wr_en, wr_addr, wr_data,
           busy, done, perf_cycles
  );

  modport slave (
    input  start, func, src_base, dst_base, len, rd_hold, rd_data, alu_pixel_out,
    output rd_en, rd_addr, alu_func, alu_pixel_in, wr_en, wr_addr, wr_data,
           busy, done, perf_cycles
  );

endinterface

// File: rtl/img_alu_seq_pipe.sv
// Two-stage valid pipeline for img_alu_seq: read-return stage feeding a
// registered write stage that holds the ALU result and destination address.
module img_alu_seq_pipe #(
  parameter int ADDR_W = img_coproc_pkg::ADDR_W_DEF,
  parameter int PIX_W  = img_coproc_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] dstBase_i,
  input  logic [PIX_W-1:0]  aluPixel_i,
  output logic              inFlight_o,
  output logic              wrEn_o,
  output logic [ADDR_W-1:0] wrAddr_o,
  output logic [PIX_W-1:0]  wrData_o
);

  import img_coproc_pkg::*;

  logic              v1_q;
  logic              v2_q;
  logic [ADDR_W-1:0] wrIndex_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [PIX_W-1:0]  wrData_q;

  // Results retire in issue order, so a running index is enough for the
  // destination address; it restarts with every accepted job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      wrIndex_q <= '0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
    end else begin
      v1_q <= issue_i;
      v2_q <= v1_q;
      if (clear_i) begin
        wrIndex_q <= '0;
      end else if (v1_q) begin
        wrData_q  <= aluPixel_i;
        wrAddr_q  <= dstBase_i + wrIndex_q;
        wrIndex_q <= wrIndex_q + ADDR_W'(1);
      end
    end
  end

  assign inFlight_o = v1_q;
  assign wrEn_o     = v2_q;
  assign wrAddr_o   = wrAddr_q;
  assign wrData_o   = wrData_q;

endmodule

// File: rtl/img_alu_seq.sv
// Frame-level sequencer streaming LEN pixels from a source region through the
// pixel ALU into a destination region. IMG_ALU_SEQ_PERF_EN adds a busy-cycle counter.
module img_alu_seq #(
  parameter int ADDR_W = img_coproc_pkg::ADDR_W_DEF,
  parameter int PIX_W  = img_coproc_pkg::PIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  img_alu_seq_if.slave bus
);

  import img_coproc_pkg::*;

  seq_state_e        state_q;
  logic [1:0]        func_q;
  logic [ADDR_W-1:0] srcBase_q;
  logic [ADDR_W-1:0] dstBase_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] issued_q;
  logic [ADDR_W-1:0] issued_d;
  logic              busy_q;
  logic              done_q;

  logic              startAccept;
  logic              issue;
  logic              inFlight;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [PIX_W-1:0]  wrData;

  assign startAccept = (state_q == IDLE) && bus.start;
  // RUN is left on the last issue, so in RUN there is always a read outstanding.
  assign issue       = (state_q == RUN) && !bus.rd_hold;
  assign issued_d    = issued_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      func_q    <= '0;
      srcBase_q <= '0;
      dstBase_q <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startAccept) begin
            func_q    <= bus.func;
            srcBase_q <= bus.src_base;
            dstBase_q <= bus.dst_base;
            len_q     <= bus.len;
            issued_q  <= '0;
            if (bus.len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issued_q <= issued_d;
            if (issued_d == len_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The write stage empties on this same edge once stage 1 is idle.
          if (!inFlight) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  img_alu_seq_pipe #(
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (startAccept),
    .issue_i   (issue),
    .dstBase_i (dstBase_q),
    .aluPixel_i(bus.alu_pixel_out),
    .inFlight_o(inFlight),
    .wrEn_o    (wrEn),
    .wrAddr_o  (wrAddr),
    .wrData_o  (wrData)
  );

  assign bus.rd_en        = issue;
  assign bus.rd_addr      = srcBase_q + issued_q;
  assign bus.alu_func     = func_q;
  assign bus.alu_pixel_in = bus.rd_data;
  assign bus.wr_en        = wrEn;
  assign bus.wr_addr      = wrAddr;
  assign bus.wr_data      = wrData;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

`ifdef IMG_ALU_SEQ_PERF_EN
  localparam int PERF_W = perfWidth(ADDR_W);

  logic [PERF_W-1:0] perfCycles_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perfCycles_q <= '0;
    end else if (startAccept) begin
      perfCycles_q <= '0;
    end else if (busy_q && (perfCycles_q != '1)) begin
      perfCycles_q <= perfCycles_q + PERF_W'(1);
    end
  end

  assign bus.perf_cycles = perfCycles_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_img_alu_seq.sv
// Bench for img_alu_seq: directed and randomized jobs checked against a
// cycle-level expectation built from the read/write latency rules.
`timescale 1ns/1ps
module tb_img_alu_seq;

  import img_coproc_pkg::*;

  localparam int AW   = 17;
  localparam int PW   = 12;
  localparam int MAXC = 256;

  logic clk;
  logic rst_n;

  img_alu_seq_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

  img_alu_seq #(.ADDR_W(AW), .PIX_W(PW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [PW-1:0] mem [0:(1<<AW)-1];
  int            checkCount = 0;
  int            errorCount = 0;
  int            obsDone;
  int            obsFirstWr;
  logic [PW-1:0] obsWrData [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer read port: data appears one cycle after the request.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  function automatic logic [3:0] stretch(input logic [3:0] c);
    if (c >= 4'd12) return 4'hF;
    if (c >= 4'd8)  return c + 4'd4;
    if (c < 4'd4)   return 4'h0;
    return c - 4'd4;
  endfunction

  function automatic logic [3:0] thresh(input logic [3:0] c);
    return (c >= 4'd7) ? 4'hF : 4'h0;
  endfunction

  // Stand-in pixel ALU living beside the sequencer.
  function automatic logic [PW-1:0] aluRef(input logic [1:0] f, input logic [PW-1:0] p);
    int sum;
    sum = int'(p[11:8]) + int'(p[7:4]) + int'(p[3:0]);
    case (f)
      FUNC_INVERT:   return ~p;
      FUNC_COLOR:    return (sum < 4) ? 12'h00F : ((sum < 10) ? 12'h0F0 : 12'hF00);
      FUNC_CONTRAST: return {stretch(p[11:8]), stretch(p[7:4]), stretch(p[3:0])};
      default:       return {thresh(p[11:8]), thresh(p[7:4]), thresh(p[3:0])};
    endcase
  endfunction

  assign bus.alu_pixel_out = aluRef(bus.alu_func, bus.alu_pixel_in);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one job. holdMode: 0 none, 1 random, 2 window [holdFrom, holdFrom+holdCount).
  task automatic applyStimulus(input logic [1:0] f, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                               input logic [AW-1:0] n, input int holdMode, input int holdFrom,
                               input int holdCount, input bit glitch);
    bit            holdArr   [MAXC];
    bit            expRd     [MAXC];
    bit            expWr     [MAXC];
    logic [AW-1:0] expRdAddr [MAXC];
    logic [AW-1:0] expWrAddr [MAXC];
    logic [PW-1:0] expWrData [MAXC];
    logic [AW-1:0] idx;
    int            issued;
    int            lastRead;
    int            doneCycle;
    int            writes;
    int            expPerf;

    for (int k = 0; k < MAXC; k++) begin
      holdArr[k]   = 1'b0;
      expRd[k]     = 1'b0;
      expWr[k]     = 1'b0;
      expRdAddr[k] = '0;
      expWrAddr[k] = '0;
      expWrData[k] = '0;
      if (holdMode == 1 && k < 200) holdArr[k] = ($urandom_range(3, 0) == 0);
      if (holdMode == 2 && k >= holdFrom && k < holdFrom + holdCount) holdArr[k] = 1'b1;
    end

    // Reads go out on every unheld cycle from T+1; each write lands two cycles later.
    issued   = 0;
    lastRead = 0;
    for (int k = 1; k < MAXC - 2; k++) begin
      if (issued < int'(n) && !holdArr[k]) begin
        idx              = AW'(issued);
        expRd[k]         = 1'b1;
        expRdAddr[k]     = src + idx;
        expWr[k+2]       = 1'b1;
        expWrAddr[k+2]   = dst + idx;
        expWrData[k+2]   = aluRef(f, mem[src + idx]);
        issued++;
        lastRead = k;
      end
    end
    doneCycle = (n == '0) ? 1 : lastRead + 3;

    bus.func     = f;
    bus.src_base = src;
    bus.dst_base = dst;
    bus.len      = n;
    bus.rd_hold  = 1'b0;
    bus.start    = 1'b1;
    nextCycle();
    bus.start = 1'b0;

    obsDone    = -1;
    obsFirstWr = -1;
    obsWrData.delete();
    writes = 0;

    for (int k = 1; k <= doneCycle + 1; k++) begin
      bus.rd_hold = holdArr[k];
      if (glitch && (k == 1 || k == doneCycle)) begin
        bus.start    = 1'b1;
        bus.func     = ~f;
        bus.len      = n + AW'(3);
        bus.src_base = src + AW'(5);
        bus.dst_base = dst + AW'(7);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("rd_en c%0d", k), 32'(bus.rd_en), 32'(expRd[k]));
      if (expRd[k]) checkOutput($sformatf("rd_addr c%0d", k), 32'(bus.rd_addr), 32'(expRdAddr[k]));
      checkOutput($sformatf("wr_en c%0d", k), 32'(bus.wr_en), 32'(expWr[k]));
      if (expWr[k]) begin
        checkOutput($sformatf("wr_addr c%0d", k), 32'(bus.wr_addr), 32'(expWrAddr[k]));
        checkOutput($sformatf("wr_data c%0d", k), 32'(bus.wr_data), 32'(expWrData[k]));
      end
      checkOutput($sformatf("done c%0d", k), 32'(bus.done), 32'(k == doneCycle));
      checkOutput($sformatf("busy c%0d", k), 32'(bus.busy), 32'(n != '0 && k < doneCycle));
      if (bus.wr_en) begin
        obsWrData.push_back(bus.wr_data);
        if (obsFirstWr < 0) obsFirstWr = k;
        writes++;
      end
      if (bus.done && obsDone < 0) obsDone = k;
      nextCycle();
    end
    bus.start   = 1'b0;
    bus.rd_hold = 1'b0;

    checkOutput("write count", 32'(writes), 32'(n));
    checkOutput("alu_func held", 32'(bus.alu_func), 32'(f));
`ifdef IMG_ALU_SEQ_PERF_EN
    expPerf = (n == '0) ? 0 : doneCycle - 1;
`else
    expPerf = 0;
`endif
    checkOutput("perf_cycles", 32'(bus.perf_cycles), 32'(expPerf));
  endtask

  task automatic applyMidJobReset();
    int seen;
    bus.func     = FUNC_CONTRAST;
    bus.src_base = 17'h00800;
    bus.dst_base = 17'h00900;
    bus.len      = 17'd16;
    bus.start    = 1'b1;
    nextCycle();
    bus.start = 1'b0;
    repeat (5) nextCycle();
    rst_n = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("rst rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("rst wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst done", 32'(bus.done), 32'd0);
    checkOutput("rst rd_addr", 32'(bus.rd_addr), 32'd0);
    checkOutput("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("rst alu_func", 32'(bus.alu_func), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rd_en || bus.wr_en || bus.done) seen++;
      nextCycle();
    end
    checkOutput("activity after reset", 32'(seen), 32'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.func     = '0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.len      = '0;
    bus.rd_hold  = 1'b0;
    rst_n        = 1'b0;

    for (int a = 0; a < (1 << AW); a++) mem[a] = PW'($urandom);

    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("reset rd_en", 32'(bus.rd_en), 32'd0);
    checkOutput("reset wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("reset perf", 32'(bus.perf_cycles), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] invert job");
    mem[17'h100] = 12'h123;
    mem[17'h101] = 12'h000;
    mem[17'h102] = 12'hFFF;
    mem[17'h103] = 12'hA5A;
    applyStimulus(FUNC_INVERT, 17'h00100, 17'h00200, 17'd4, 0, 0, 0, 1'b0);
    checkOutput("invert first wr", 32'(obsFirstWr), 32'd3);
    checkOutput("invert done", 32'(obsDone), 32'd7);
    checkOutput("invert px0", 32'(obsWrData.size() > 0 ? obsWrData[0] : 12'h0), 32'h0EDC);
    checkOutput("invert px1", 32'(obsWrData.size() > 1 ? obsWrData[1] : 12'h0), 32'h0FFF);
    checkOutput("invert px2", 32'(obsWrData.size() > 2 ? obsWrData[2] : 12'hFFF), 32'h0000);
    checkOutput("invert px3", 32'(obsWrData.size() > 3 ? obsWrData[3] : 12'h0), 32'h05A5);

    $display("[TB] threshold and color map");
    mem[17'h300] = 12'h7A6;
    applyStimulus(FUNC_THRESH, 17'h00300, 17'h00400, 17'd1, 0, 0, 0, 1'b0);
    checkOutput("thresh px", 32'(obsWrData.size() > 0 ? obsWrData[0] : 12'h0), 32'h0FF0);
    mem[17'h310] = 12'h050;
    mem[17'h311] = 12'h0E0;
    applyStimulus(FUNC_COLOR, 17'h00310, 17'h00410, 17'd2, 0, 0, 0, 1'b0);
    checkOutput("color px0", 32'(obsWrData.size() > 0 ? obsWrData[0] : 12'h0), 32'h00F0);
    checkOutput("color px1", 32'(obsWrData.size() > 1 ? obsWrData[1] : 12'h0), 32'h0F00);

    $display("[TB] read hold window");
    applyStimulus(FUNC_CONTRAST, 17'h00500, 17'h00600, 17'd8, 2, 3, 3, 1'b0);
    checkOutput("hold done", 32'(obsDone), 32'd14);

    $display("[TB] zero length and ignored starts");
    applyStimulus(FUNC_INVERT, 17'h00700, 17'h00710, 17'd0, 0, 0, 0, 1'b0);
    checkOutput("len0 done", 32'(obsDone), 32'd1);
    applyStimulus(FUNC_COLOR, 17'h00720, 17'h00730, 17'd2, 0, 0, 0, 1'b1);

    $display("[TB] address wrap");
    applyStimulus(FUNC_INVERT, 17'h1FFFF, 17'h1FFFE, 17'd3, 0, 0, 0, 1'b0);

    $display("[TB] reset during run");
    applyMidJobReset();
    applyStimulus(FUNC_INVERT, 17'h00100, 17'h00A00, 17'd4, 0, 0, 0, 1'b0);
    checkOutput("post-reset done", 32'(obsDone), 32'd7);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 24; j++) begin
      applyStimulus(2'($urandom_range(3, 0)), AW'($urandom), AW'($urandom),
                    AW'($urandom_range(24, 0)), int'($urandom_range(1, 0)), 0, 0,
                    1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
